// File: rtl/approx_mult_pkg.sv
// Shared constants and golden arithmetic model for the approximate multiplier.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   WIDTH_MIN / WIDTH_MAX  - legal operand width range
//   APPROX_COLS_MIN        - smallest legal approximated column count (max is WIDTH)
//   approx_product()       - bit-level reference of exact / approximate product
package approx_mult_pkg;

  localparam int WIDTH_MIN       = 2;
  localparam int WIDTH_MAX       = 16;
  localparam int APPROX_COLS_MIN = 0;

  // Reference product for operands up to WIDTH_MAX bits. Partial product
  // pp(i,j) = a[i] & b[j] lands in column i+j. In approximate mode, columns
  // below k are OR-collapsed (no carry); all other columns are summed exactly.
  function automatic logic [31:0] approx_product(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        approx,
    input int          width,
    input int          k
  );
    logic [31:0] hi;
    logic [31:0] lo;
    logic [15:0] a_sh;
    logic [15:0] b_sh;
    hi = '0;
    lo = '0;
    for (int i = 0; i < width; i++) begin
      for (int j = 0; j < width; j++) begin
        a_sh = a >> i;
        b_sh = b >> j;
        if (a_sh[0] && b_sh[0]) begin
          if (approx && ((i + j) < k)) begin
            lo = lo | (32'd1 << (i + j));
          end else begin
            hi = hi + (32'd1 << (i + j));
          end
        end
      end
    end
    return hi | lo;
  endfunction

endpackage

// File: rtl/approx_pp_sum.sv
// Combinational partial-product matrix: exact product or low-column OR-approximation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
//
// Ports:
//   a_i, b_i  - unsigned operands, WIDTH bits
//   approx_i  - 1 selects the approximate product, 0 the exact product
//   result_o  - 2*WIDTH-bit product
module approx_pp_sum
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int APPROX_COLS = 3
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               approx_i,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    hi_sum;
  logic [PW-1:0]    lo_or;
  logic [PW-1:0]    exact;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             pp;

  // Walk the full matrix once. Bits in the low APPROX_COLS columns are only
  // OR-ed into their column, so nothing ever carries out of that region;
  // everything from column APPROX_COLS upward is accumulated with full carry.
  always_comb begin
    hi_sum = '0;
    lo_or  = '0;
    a_sh   = '0;
    b_sh   = '0;
    pp     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        a_sh = a_i >> i;
        b_sh = b_i >> j;
        pp   = a_sh[0] & b_sh[0];
        if ((i + j) < APPROX_COLS) begin
          lo_or = lo_or | (PW'(pp) << (i + j));
        end else begin
          hi_sum = hi_sum + (PW'(pp) << (i + j));
        end
      end
    end
  end

  assign exact = PW'(a_i) * PW'(b_i);

  // hi_sum and lo_or occupy disjoint bit ranges, so OR is the same as add.
  assign result_o = approx_i ? (hi_sum | lo_or) : exact;

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined WIDTH x WIDTH multiplier with per-beat exact/approximate mode.
// Latency: 2 cycles from input handshake to out_valid; 1 beat/cycle throughput.
// Backpressure: in_ready drops only when both stages hold beats and out_ready=0.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   in_valid/in_ready               - operand handshake (in_a, in_b, in_approx)
//   out_valid/out_ready             - result handshake (out_result, out_approx)
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int APPROX_COLS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_approx
);

  localparam int PW = 2 * WIDTH;

  generate
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX) ||
        (APPROX_COLS < APPROX_COLS_MIN) || (APPROX_COLS > WIDTH)) begin : g_bad_param
      $error("approx_mult_pipe: illegal WIDTH=%0d / APPROX_COLS=%0d", WIDTH, APPROX_COLS);
    end
  endgenerate

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             approx;
  } s1_t;

  // Stage 1: captured operands
  logic          s1_vld_q, s1_vld_d;
  s1_t           s1_dat_q, s1_dat_d;

  // Stage 2: registered result
  logic          s2_vld_q, s2_vld_d;
  logic [PW-1:0] s2_res_q, s2_res_d;
  logic          s2_mode_q, s2_mode_d;

  logic          adv1;
  logic          adv2;
  logic [PW-1:0] prod;

  approx_pp_sum #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_pp_sum (
    .a_i      (s1_dat_q.a),
    .b_i      (s1_dat_q.b),
    .approx_i (s1_dat_q.approx),
    .result_o (prod)
  );

  always_comb begin
    // A stage may advance when it is empty or the stage after it is draining.
    adv2 = !s2_vld_q || out_ready;
    adv1 = !s1_vld_q || adv2;

    s1_vld_d  = s1_vld_q;
    s1_dat_d  = s1_dat_q;
    s2_vld_d  = s2_vld_q;
    s2_res_d  = s2_res_q;
    s2_mode_d = s2_mode_q;

    if (adv2) begin
      s2_vld_d = s1_vld_q;
      // Data only moves with a valid beat, so an empty stage 1 never
      // overwrites the held result with stale or unknown operands.
      if (s1_vld_q) begin
        s2_res_d  = prod;
        s2_mode_d = s1_dat_q.approx;
      end
    end

    if (adv1) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_dat_d.a      = in_a;
        s1_dat_d.b      = in_b;
        s1_dat_d.approx = in_approx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_res_q  <= '0;
      s2_mode_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
      s2_vld_q  <= s2_vld_d;
      s2_res_q  <= s2_res_d;
      s2_mode_q <= s2_mode_d;
    end
  end

  assign in_ready   = adv1;
  assign out_valid  = s2_vld_q;
  assign out_result = s2_res_q;
  assign out_approx = s2_mode_q;

`ifndef SYNTHESIS
  // Every product that moves into stage 2 must agree with the reference model.
  always_ff @(posedge clk) begin
    if (!rst && s1_vld_q && adv2) begin
      assert (32'(prod) == approx_product(16'(s1_dat_q.a), 16'(s1_dat_q.b),
                                          s1_dat_q.approx, WIDTH, APPROX_COLS))
      else $error("approx_mult_pipe: product disagrees with reference model");
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Main DUT: WIDTH=4, APPROX_COLS=3
  logic       in_valid, in_ready, in_approx;
  logic [3:0] in_a, in_b;
  logic       out_valid, out_ready, out_approx;
  logic [7:0] out_result;

  // Sweep DUTs: WIDTH=4, APPROX_COLS = 0 / 2 / 4, shared inputs
  logic       sw_valid, sw_approx;
  logic [3:0] sw_a, sw_b;
  logic       k0_in_ready, k2_in_ready, k4_in_ready;
  logic       k0_valid, k2_valid, k4_valid;
  logic       k0_mode, k2_mode, k4_mode;
  logic [7:0] k0_res, k2_res, k4_res;

  // Random DUT: WIDTH=8, APPROX_COLS=5
  logic        r_valid, r_in_ready, r_approx, r_out_valid, r_out_ready, r_out_approx;
  logic [7:0]  r_a, r_b;
  logic [15:0] r_result;

  approx_mult_pipe #(.WIDTH(4), .APPROX_COLS(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_approx(out_approx));

  approx_mult_pipe #(.WIDTH(4), .APPROX_COLS(0)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(k0_in_ready), .in_a(sw_a), .in_b(sw_b),
    .in_approx(sw_approx), .out_valid(k0_valid), .out_ready(1'b1),
    .out_result(k0_res), .out_approx(k0_mode));

  approx_mult_pipe #(.WIDTH(4), .APPROX_COLS(2)) u_k2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(k2_in_ready), .in_a(sw_a), .in_b(sw_b),
    .in_approx(sw_approx), .out_valid(k2_valid), .out_ready(1'b1),
    .out_result(k2_res), .out_approx(k2_mode));

  approx_mult_pipe #(.WIDTH(4), .APPROX_COLS(4)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(k4_in_ready), .in_a(sw_a), .in_b(sw_b),
    .in_approx(sw_approx), .out_valid(k4_valid), .out_ready(1'b1),
    .out_result(k4_res), .out_approx(k4_mode));

  approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(5)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_in_ready), .in_a(r_a), .in_b(r_b),
    .in_approx(r_approx), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_result(r_result), .out_approx(r_out_approx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one beat on the main DUT (pipeline assumed drained, out_ready=1) and
  // return the first result seen plus the number of edges it took.
  task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic m,
                          output logic [7:0] res, output logic mode, output int edges);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_approx = m;
    #1;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && edges < 10) begin
      @(posedge clk);
      edges++;
      #1;
    end
    res  = out_result;
    mode = out_approx;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++;
    if (out_result !== 8'd0) begin n_fail++; $display("FAIL reset_out_result got=%0d want=0", out_result); end
    n_tests++;
    if (out_approx !== 1'b0) begin n_fail++; $display("FAIL reset_out_approx got=%b want=0", out_approx); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_exact;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] ve [3];
    logic [7:0] res;
    logic       mode;
    int         edges;
    va = '{4'd15, 4'd0,  4'd15};
    vb = '{4'd15, 4'd13, 4'd1};
    ve = '{8'd225, 8'd0, 8'd15};
    for (int i = 0; i < 3; i++) begin
      send_one(va[i], vb[i], 1'b0, res, mode, edges);
      n_tests++;
      if (res !== ve[i] || mode !== 1'b0)
        begin n_fail++; $display("FAIL exact_%0dx%0d got=%0d/%b want=%0d/0", va[i], vb[i], res, mode, ve[i]); end
      n_tests++;
      if (edges != 2) begin n_fail++; $display("FAIL exact_latency got=%0d want=2", edges); end
    end
  endtask

  task automatic test_approx;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] ve [3];
    logic [7:0] res;
    logic       mode;
    int         edges;
    va = '{4'd15,  4'd3, 4'd5};
    vb = '{4'd15,  4'd3, 4'd6};
    ve = '{8'd215, 8'd7, 8'd30};
    for (int i = 0; i < 3; i++) begin
      send_one(va[i], vb[i], 1'b1, res, mode, edges);
      n_tests++;
      if (res !== ve[i] || mode !== 1'b1)
        begin n_fail++; $display("FAIL approx_%0dx%0d got=%0d/%b want=%0d/1", va[i], vb[i], res, mode, ve[i]); end
      n_tests++;
      if (edges != 2) begin n_fail++; $display("FAIL approx_latency got=%0d want=2", edges); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] obs_res  [8];
    logic       obs_mode [8];
    int         obs_cyc  [8];
    int         cnt;
    logic [7:0] want;
    cnt = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n < 4) begin
        in_valid  = 1'b1;
        in_a      = 4'd15;
        in_b      = 4'd15;
        in_approx = n[0];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (out_valid && cnt < 8) begin
        obs_res[cnt]  = out_result;
        obs_mode[cnt] = out_approx;
        obs_cyc[cnt]  = n;
        cnt++;
      end
    end
    n_tests++;
    if (cnt != 4) begin n_fail++; $display("FAIL b2b_count got=%0d want=4", cnt); end
    for (int i = 0; i < 4 && i < cnt; i++) begin
      want = i[0] ? 8'd215 : 8'd225;
      n_tests++;
      if (obs_res[i] !== want || obs_mode[i] !== i[0] || obs_cyc[i] != i + 1)
        begin n_fail++; $display("FAIL b2b_beat%0d got=%0d/%b@%0d want=%0d/%b@%0d",
                                 i, obs_res[i], obs_mode[i], obs_cyc[i], want, i[0], i + 1); end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] ba [3];
    logic [3:0] bb [3];
    logic       bm [3];
    logic [7:0] er [3];
    logic       em [3];
    int         idx, got, cyc;
    logic       acc, pop;
    ba = '{4'd15, 4'd3, 4'd5};
    bb = '{4'd15, 4'd3, 4'd6};
    bm = '{1'b0,  1'b1, 1'b0};
    er = '{8'd225, 8'd7, 8'd30};
    em = '{1'b0,  1'b1, 1'b0};
    idx = 0;
    got = 0;
    cyc = 0;
    while (cyc < 20 && got < 3) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 3);
      if (idx < 3) begin
        in_a      = ba[idx];
        in_b      = bb[idx];
        in_approx = bm[idx];
      end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 8'd225)
          begin n_fail++; $display("FAIL bp_stall_c%0d got rdy=%b vld=%b res=%0d want rdy=0 vld=1 res=225",
                                   cyc, in_ready, out_valid, out_result); end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        n_tests++;
        if (got > 2 || out_result !== er[got] || out_approx !== em[got])
          begin n_fail++; $display("FAIL bp_pop%0d got=%0d/%b", got, out_result, out_approx); end
        got++;
      end
      if (acc) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 3 || idx != 3) begin n_fail++; $display("FAIL bp_totals got pops=%0d accepts=%0d want 3/3", got, idx); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate got out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] res;
    logic       mode;
    int         edges;
    logic       ghost;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'd15;
    in_b      = 4'd15;
    in_approx = 1'b0;
    @(posedge clk);
    #1;
    in_a      = 4'd3;
    in_b      = 4'd3;
    in_approx = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_full got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_result !== 8'd0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_clear got vld=%b res=%0d rdy=%b want 0/0/1",
                               out_valid, out_result, in_ready); end
    out_ready = 1'b1;
    ghost = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) ghost = 1'b1;
    end
    n_tests++;
    if (ghost !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ghost got out_valid=1 want=0"); end
    send_one(4'd5, 4'd6, 1'b0, res, mode, edges);
    n_tests++;
    if (res !== 8'd30 || mode !== 1'b0 || edges != 2)
      begin n_fail++; $display("FAIL rst_mid_after got=%0d/%b lat=%0d want=30/0 lat=2", res, mode, edges); end
  endtask

  task automatic test_sweep_w4;
    logic [8:0] q [$];
    logic [8:0] e;
    logic [3:0] a, b;
    logic       m;
    int         popped;
    popped = 0;
    for (int n = 0; n < 516; n++) begin
      if (n < 512) begin
        sw_valid  = 1'b1;
        sw_a      = 4'(n >> 5);
        sw_b      = 4'(n >> 1);
        sw_approx = n[0];
        q.push_back({sw_a, sw_b, sw_approx});
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      if (k0_valid) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL sweep_spurious output");
        end else begin
          e = q.pop_front();
          a = e[8:5];
          b = e[4:1];
          m = e[0];
          popped++;
          n_tests++;
          if (k0_res !== 8'(8'(a) * 8'(b)) || k0_mode !== m)
            begin n_fail++; $display("FAIL sweep_k0 %0dx%0d m=%b got=%0d", a, b, m, k0_res); end
          n_tests++;
          if (k2_valid !== 1'b1 || 32'(k2_res) !== approx_product(16'(a), 16'(b), m, 4, 2) || k2_mode !== m)
            begin n_fail++; $display("FAIL sweep_k2 %0dx%0d m=%b got=%0d", a, b, m, k2_res); end
          n_tests++;
          if (k4_valid !== 1'b1 || 32'(k4_res) !== approx_product(16'(a), 16'(b), m, 4, 4) || k4_mode !== m)
            begin n_fail++; $display("FAIL sweep_k4 %0dx%0d m=%b got=%0d", a, b, m, k4_res); end
          if (a == 4'd15 && b == 4'd15 && m) begin
            n_tests++;
            if (k2_res !== 8'd223 || k4_res !== 8'd191)
              begin n_fail++; $display("FAIL sweep_corner got k2=%0d k4=%0d want 223/191", k2_res, k4_res); end
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (popped != 512 || k0_in_ready !== 1'b1 || k2_in_ready !== 1'b1 || k4_in_ready !== 1'b1)
      begin n_fail++; $display("FAIL sweep_count got=%0d want=512", popped); end
  endtask

  task automatic test_random_w8;
    logic [16:0] q [$];
    logic [16:0] e;
    int          sent, got, cycles;
    logic        acc, pop, hold_prev;
    logic [15:0] prev_res;
    logic        prev_mode;
    sent = 0;
    got = 0;
    cycles = 0;
    hold_prev = 1'b0;
    prev_res = '0;
    prev_mode = 1'b0;
    acc = 1'b1;
    while (got < 10000 && cycles < 60000) begin
      if (!r_valid || acc) begin
        r_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        r_a      = 8'($urandom_range(0, 255));
        r_b      = 8'($urandom_range(0, 255));
        r_approx = 1'($urandom_range(0, 1));
      end
      r_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold_prev) begin
        n_tests++;
        if (r_out_valid !== 1'b1 || r_result !== prev_res || r_out_approx !== prev_mode)
          begin n_fail++; $display("FAIL rand_hold got=%0d/%b want=%0d/%b", r_result, r_out_approx, prev_res, prev_mode); end
      end
      acc = r_valid && r_in_ready;
      pop = r_out_valid && r_out_ready;
      if (pop) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious got=%0d", r_result);
        end else begin
          e = q.pop_front();
          if (r_result !== e[15:0] || r_out_approx !== e[16])
            begin n_fail++; $display("FAIL rand_beat%0d got=%0d/%b want=%0d/%b", got, r_result, r_out_approx, e[15:0], e[16]); end
        end
        got++;
      end
      if (acc) begin
        q.push_back({r_approx, 16'(approx_product(16'(r_a), 16'(r_b), r_approx, 8, 5))});
        sent++;
      end
      hold_prev = r_out_valid && !r_out_ready;
      prev_res  = r_result;
      prev_mode = r_out_approx;
      @(posedge clk);
      #1;
      cycles++;
    end
    r_valid = 1'b0;
    n_tests++;
    if (got != 10000 || q.size() != 0)
      begin n_fail++; $display("FAIL rand_total got=%0d left=%0d want=10000/0 cycles=%0d", got, q.size(), cycles); end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_approx   = 1'b0;
    out_ready   = 1'b1;
    sw_valid    = 1'b0;
    sw_a        = '0;
    sw_b        = '0;
    sw_approx   = 1'b0;
    r_valid     = 1'b0;
    r_a         = '0;
    r_b         = '0;
    r_approx    = 1'b0;
    r_out_ready = 1'b0;
    test_reset;
    out_ready = 1'b1;
    test_exact;
    test_approx;
    test_back_to_back;
    test_backpressure;
    test_reset_midstream;
    test_sweep_w4;
    test_random_w8;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
